// File: rtl/shift_issue_stage.sv
// Issue/capture stage around the external 32-bit barrel left shifter: request FIFO -> shifter -> result slot.
// Optional macro SHIFT_OVERFLOW_FLAG_EN adds out_ovf, set when a non-zero bit is shifted out.
module shift_issue_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sh_data,
    output logic [4:0]       sh_shamt,
    input  logic [31:0]      sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef SHIFT_OVERFLOW_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    logic [31:0]      r_data  [DEPTH];
    logic [4:0]       r_shamt [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    slot_state_t      r_state;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_data;
    logic [4:0]       w_head_shamt;
    logic [TAG_W-1:0] w_head_tag;

    // A full FIFO refuses even when a pop frees an entry in the same cycle.
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == CNT_W'(DEPTH));
        in_ready = reset & ~w_full;
        w_push   = in_valid & in_ready;
        w_pop    = ~w_empty & ((r_state == SLOT_EMPTY) | out_ready);
    end

    always_comb begin
        w_head_data  = '0;
        w_head_shamt = '0;
        w_head_tag   = '0;
        if (!w_empty) begin
            w_head_data  = r_data[r_rd_ptr];
            w_head_shamt = r_shamt[r_rd_ptr];
            w_head_tag   = r_tag[r_rd_ptr];
        end
    end

    assign sh_data  = w_head_data;
    assign sh_shamt = w_head_shamt;

    // NOTE: the payload storage carries no reset; count and pointers decide which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wr_ptr]  <= in_data;
            r_shamt[r_wr_ptr] <= in_shamt;
            r_tag[r_wr_ptr]   <= in_tag;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= SLOT_EMPTY;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else if (w_pop) begin
            r_state      <= SLOT_FULL;
            r_out_result <= sh_result;
            r_out_tag    <= w_head_tag;
        end else if (r_state == SLOT_FULL && out_ready) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign out_valid  = (r_state == SLOT_FULL);
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign busy       = ~w_empty | out_valid;

`ifdef SHIFT_OVERFLOW_FLAG_EN
    logic w_ovf;
    logic r_out_ovf;

    // Bits shifted out are the top shamt bits of the head operand.
    assign w_ovf = |(w_head_data & ~(32'hFFFF_FFFF >> w_head_shamt));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out_ovf <= 1'b0;
        end else if (w_pop) begin
            r_out_ovf <= w_ovf;
        end
    end

    assign out_ovf = r_out_ovf;
`endif

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Sequential issue/capture stage wrapped around the 32-bit barrel left shifter in SimpleALU.
- Buffers shift requests from the ALU operand path in a small FIFO and presents the head entry's data and shift amount to the combinational shifter.
- Registers the shifter's result into a handshaked output slot for the writeback mux.
- Decouples the shifter's combinational depth from both the operand and writeback paths.

Parameters:
DEPTH, 2, request FIFO entries; power of two, at least 2.
TAG_W, 4, width of the opaque request tag carried alongside each request.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
in_valid  input  1  request valid.
in_ready  output  1  stage can accept a request.
in_data  input  32  operand to shift.
in_shamt  input  5  shift amount, 0-31.
in_tag  input  TAG_W  request tag.
sh_data  output  32  operand driven to the shifter.
sh_shamt  output  5  shift amount driven to the shifter.
sh_result  input  32  combinational result returned by the shifter.
out_valid  output  1  result slot holds a valid result.
out_ready  input  1  consumer accepts the result.
out_result  output  32  registered shift result.
out_tag  output  TAG_W  tag of out_result.
busy  output  1  high when the FIFO or the result slot is non-empty.

Behaviour:
- Reset (reset low at an edge):
  - FIFO count, read pointer and write pointer go to 0.
  - out_valid=0, out_result=0, out_tag=0.
  - in_ready=0 combinationally while reset is low.
- Request handshake:
  - in_ready = reset & (count != DEPTH).
  - Push occurs on an edge where in_valid & in_ready; write pointer wraps modulo DEPTH.
  - A full FIFO never accepts, even if a pop happens in the same cycle.
  - Payload must hold while in_valid is high and in_ready is low.
- Shifter drive:
  - sh_data/sh_shamt show the FIFO head combinationally.
  - When the FIFO is empty they are forced to 0.
- Result slot has two states, SLOT_EMPTY and SLOT_FULL:
  - pop = (count != 0) & (SLOT_EMPTY | out_ready).
  - On pop: out_result <= sh_result, out_tag <= head tag, out_valid <= 1, read pointer advances.
  - SLOT_FULL & out_ready & no pop: out_valid <= 0, go to SLOT_EMPTY; out_result keeps its last value.
  - SLOT_FULL & !out_ready: hold everything, no pop (backpressure propagates to the FIFO).
- Count update:
  - count += push - pop.
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - A push into an empty FIFO is not visible to pop until the next cycle.
- Latency: a request accepted at edge k into an idle stage gives out_valid=1 after edge k+1. Sustained throughput is 1 result/cycle with out_ready held high.
- Ordering: results leave strictly in acceptance order; tags are never reordered or dropped.
- busy = (count != 0) | out_valid.
- Reset mid-operation: all pending entries and any held result are discarded, with no output pulse.

Optional Feature:
- Macro SHIFT_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output out_ovf (1 bit), registered alongside out_result.
  - out_ovf = 1 when any bit shifted out of the head operand is non-zero, i.e. (head_data >> (32 - head_shamt)) != 0 for shamt > 0. out_ovf is 0 for shamt = 0.
  - out_ovf resets to 0 and holds with out_result.
- When undefined: no out_ovf port and no associated logic.

Test Plan:
- Reset: drive reset low for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0. After release, in_ready=1.
- Single request: in_data=0x0000_0001, shamt=31, tag=3 accepted at edge k; shifter returns 0x8000_0000 -> after edge k+1, out_valid=1, out_result=0x8000_0000, out_tag=3.
- Streaming: 8 back-to-back requests with data=i+1, shamt=i, out_ready=1 -> 8 consecutive results (i+1)<<i in order, with no gap cycles.
- Backpressure: out_ready=0 with DEPTH=2 -> stage accepts 3 requests (2 FIFO entries + slot), then in_ready=0. Raising out_ready drains all 3 in order over 3 cycles.
- Reset mid-stream: reset low while count=2 and out_valid=1 -> next cycle count=0, out_valid=0. Post-reset requests complete normally.
- SHIFT_OVERFLOW_FLAG_EN defined:
  - data=0x4000_0000, shamt=2 -> out_ovf=1.
  - data=0x0000_FFFF, shamt=16 -> out_ovf=0.
